// File: rtl/axi_data_responder.sv
// axi_data_responder
//   Single-outstanding AXI-style memory responder backed by a 2^ADDR_W x 32-bit
//   word memory with byte-lane writes and a fixed, parameterised read latency.
//
// Ports
//   clk, resetn                      clock, synchronous active-low reset
//   araddr, arsize, arvalid, arready read address channel (byte address)
//   rdata, rvalid, rready            read data channel (full word, registered)
//   awaddr, awsize, awvalid, awready write address channel (byte address)
//   wdata, wvalid, wready            write data channel (lane-aligned data)
//   bvalid, bready                   write response channel
//
// Writes take priority over reads in IDLE. Reads always return the whole word;
// the requester extracts the byte or half it wants.
module axi_data_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] araddr,
    input  logic [1:0]  arsize,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic [1:0]  awsize,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic        wvalid,
    output logic        wready,
    output logic        bvalid,
    input  logic        bready
);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_DATA, WR_RESP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] wr_idx;
    logic [1:0]        wr_lo;
    logic [1:0]        wr_size;
    logic [3:0]        cnt;
    logic [3:0]        strb;
    logic              wr_en;

    logic [31:0] mem [2**ADDR_W];

    // Byte-offset bits, upper alias bits and arsize carry no meaning here.
    logic unused;
    assign unused = ^{araddr[31:ADDR_W+2], araddr[1:0], arsize, awaddr[31:ADDR_W+2]};

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        arready   = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        rvalid    = 1'b0;
        case (state)
            IDLE: begin
                awready = 1'b1;
                arready = !awvalid;     // pending write wins
                if (awvalid)      state_nxt = WR_DATA;
                else if (arvalid) state_nxt = RD_WAIT;
            end
            RD_WAIT: if (cnt == 4'd1) state_nxt = RD_RESP;
            RD_RESP: begin
                rvalid = 1'b1;
                if (rready) state_nxt = IDLE;
            end
            WR_DATA: begin
                wready = 1'b1;
                if (wvalid) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                bvalid = 1'b1;
                if (bready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lane enables from the latched size and low address bits
    always_comb begin
        case (wr_size)
            2'd0:    strb = 4'b0001 << wr_lo;
            2'd1:    strb = wr_lo[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
    end

    assign wr_en = resetn && (state == WR_DATA) && wvalid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            rdata   <= '0;
            cnt     <= '0;
            rd_idx  <= '0;
            wr_idx  <= '0;
            wr_lo   <= '0;
            wr_size <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (awvalid) begin
                    wr_idx  <= awaddr[ADDR_W+1:2];
                    wr_lo   <= awaddr[1:0];
                    wr_size <= awsize;
                end else if (arvalid) begin
                    rd_idx <= araddr[ADDR_W+1:2];
                    cnt    <= 4'(LATENCY);
                end
            end
            if (state == RD_WAIT) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) rdata <= mem[rd_idx];
            end
        end
    end

    // Memory is not reset; a reset on the W handshake edge blocks the write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++)
                if (strb[k]) mem[wr_idx][8*k +: 8] <= wdata[8*k +: 8];
        end
    end

endmodule
